// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: reads instruction memory over req/ack, latches the IR,
// and issues one PC strobe per instruction. Halt or memory timeout parks the FSM until reset.
`timescale 1ns/1ps
module instr_fetch #(
  parameter int         IW      = 16,
  parameter logic [3:0] OP_HALT = 4'h0,
  parameter logic [3:0] OP_JMP  = 4'hE,
  parameter logic [3:0] OP_JZ   = 4'hF,
  parameter int         TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [7:0]    ins_addr,
  output logic [7:0]    mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_data,
  input  logic          z_flag,
  input  logic          exec_busy,
  output logic [IW-1:0] ir,
  output logic          instr_valid,
  output logic          pc_inc,
  output logic          pc_load,
  output logic [7:0]    pc_target,
  output logic          halted,
  output logic          fetch_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] ISSUE = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic          req_q, req_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          inc_q, inc_d;
  logic          load_q, load_d;
  logic [7:0]    target_q, target_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;

  logic [3:0] opcode;
  logic [3:0] cnt_inc;

  assign opcode  = ir_q[IW-1:IW-4];
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    req_d    = req_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    err_d    = err_q;
    // Strobes default low so every issue produces a single-cycle pulse.
    valid_d  = 1'b0;
    inc_d    = 1'b0;
    load_d   = 1'b0;
    target_d = 8'h00;

    case (state_q)
      IDLE: begin
        if (enable && !halted_q && !err_q) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = ins_addr;
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d   = 4'd0;
      end
      WAIT: begin
        // Ack wins over the timeout so an ack on the final allowed cycle is taken.
        if (mem_ack) begin
          ir_d    = mem_data;
          req_d   = 1'b0;
          state_d = LATCH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = STOP;
          end
        end
      end
      LATCH: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!exec_busy) begin
          valid_d = 1'b1;
          state_d = IDLE;
          if (opcode == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = STOP;
          end else if ((opcode == OP_JMP) || ((opcode == OP_JZ) && z_flag)) begin
            load_d   = 1'b1;
            target_d = ir_q[7:0];
          end else begin
            inc_d = 1'b1;
          end
        end
      end
      STOP: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= 8'h00;
      req_q    <= 1'b0;
      ir_q     <= '0;
      cnt_q    <= 4'd0;
      valid_q  <= 1'b0;
      inc_q    <= 1'b0;
      load_q   <= 1'b0;
      target_q <= 8'h00;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      inc_q    <= inc_d;
      load_q   <= load_d;
      target_q <= target_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_req     = req_q;
  assign ir          = ir_q;
  assign instr_valid = valid_q;
  assign pc_inc      = inc_q;
  assign pc_load     = load_q;
  assign pc_target   = target_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected issue results are queued when an instruction
// is driven and popped when the strobe cycle is observed.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  ins_addr = 8'h00;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        z_flag = 1'b0;
  logic        exec_busy = 1'b0;
  logic [15:0] ir;
  logic        instr_valid;
  logic        pc_inc;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        halted;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch #(.IW(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ins_addr(ins_addr),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .z_flag(z_flag), .exec_busy(exec_busy), .ir(ir), .instr_valid(instr_valid),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .halted(halted), .fetch_err(fetch_err)
  );

  typedef struct {
    logic [15:0] ir;
    logic        inc;
    logic        load;
    logic [7:0]  tgt;
    logic        halt;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [15:0] ir;
    logic        inc;
    logic        load;
    logic [7:0]  tgt;
    logic        halt;
    int          lat;
    bit          req_ok;
    bit          quiet;
    bit          single;
    bit          req_after;
  } obs_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  logic [37:0] out_vec;
  assign out_vec = {ir, mem_addr, mem_req, instr_valid, pc_inc, pc_load, pc_target, halted, fetch_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] w, input logic z);
    exp_t e;
    e.ir = w; e.inc = 1'b0; e.load = 1'b0; e.tgt = 8'h00; e.halt = 1'b0;
    case (w[15:12])
      4'h0: e.halt = 1'b1;
      4'hE: begin e.load = 1'b1; e.tgt = w[7:0]; end
      4'hF: if (z) begin e.load = 1'b1; e.tgt = w[7:0]; end else e.inc = 1'b1;
      default: e.inc = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [27:0] pk_obs(input obs_t o);
    return {o.valid, o.ir, o.inc, o.load, o.tgt, o.halt};
  endfunction

  function automatic logic [27:0] pk_exp(input exp_t e);
    return {1'b1, e.ir, e.inc, e.load, e.tgt, e.halt};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0; mem_ack = 1'b0; exec_busy = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  // Runs one instruction through the DUT; lat counts cycles from the REQ cycle to the strobe cycle.
  task automatic do_instr(input logic [7:0] addr, input logic [15:0] w, input logic z,
                          input int ack_dly, input int busy, input bit keep,
                          input logic [7:0] nxt, output obs_t o);
    int n;
    n = 0;
    o.valid = 1'b0; o.ir = '0; o.inc = 1'b0; o.load = 1'b0; o.tgt = '0; o.halt = 1'b0;
    o.lat = 0; o.req_ok = 1'b0; o.quiet = 1'b0; o.single = 1'b0; o.req_after = 1'b0;
    ins_addr = addr; mem_data = w; z_flag = z; exec_busy = 1'b0; mem_ack = 1'b0; enable = 1'b1;
    sb.push_back(model(w, z));
    while (!mem_req && n < 8) begin step(); n++; end
    if (!mem_req) begin enable = 1'b0; return; end
    o.req_ok = (mem_addr == addr);
    o.quiet = 1'b1;
    mem_ack = 1'b1; mem_data = ~w;
    step(); o.lat++;
    mem_ack = 1'b0; mem_data = w;
    for (int i = 0; i < ack_dly; i++) begin
      o.req_ok &= (mem_req && mem_addr == addr);
      o.quiet &= !(instr_valid | pc_inc | pc_load);
      step(); o.lat++;
    end
    o.req_ok &= (mem_req && mem_addr == addr);
    mem_ack = 1'b1; exec_busy = (busy > 0);
    step(); o.lat++;
    mem_ack = 1'b0;
    o.req_ok &= !mem_req;
    o.quiet &= !(instr_valid | pc_inc | pc_load);
    step(); o.lat++;
    for (int i = 0; i < busy; i++) begin
      o.quiet &= !(instr_valid | pc_inc | pc_load);
      mem_ack = 1'b1; mem_data = ~w;
      step(); o.lat++;
    end
    o.quiet &= !(instr_valid | pc_inc | pc_load);
    mem_ack = 1'b0; mem_data = w; exec_busy = 1'b0;
    step(); o.lat++;
    o.valid = instr_valid; o.ir = ir; o.inc = pc_inc; o.load = pc_load;
    o.tgt = pc_target; o.halt = halted;
    if (keep) ins_addr = nxt; else enable = 1'b0;
    step();
    o.single = !(instr_valid | pc_inc | pc_load) && (pc_target == 8'h00);
    o.req_after = mem_req;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_vec !== 38'h0) begin
      fails++; $display("FAIL reset_async: outputs=%h expected=%h", out_vec, 38'h0);
    end
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (out_vec !== 38'h0) begin
      fails++; $display("FAIL reset_idle: outputs=%h expected=%h", out_vec, 38'h0);
    end
  endtask

  task automatic test_basic();
    obs_t o; exp_t e;
    do_instr(8'h00, 16'h1234, 1'b0, 0, 0, 1'b1, 8'h01, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e)) begin
      fails++; $display("FAIL basic_issue: got=%h expected=%h", pk_obs(o), pk_exp(e));
    end
    checks++;
    if ({o.lat, o.req_ok, o.quiet, o.single, o.req_after} !== {32'd4, 4'b1111}) begin
      fails++; $display("FAIL basic_timing: lat=%0d req_ok=%b quiet=%b single=%b next_req=%b expected lat=4 all 1",
                        o.lat, o.req_ok, o.quiet, o.single, o.req_after);
    end
    do_instr(8'h01, 16'h2000, 1'b0, 0, 0, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e) || !o.req_ok) begin
      fails++; $display("FAIL basic_second: got=%h req_ok=%b expected=%h req_ok=1", pk_obs(o), o.req_ok, pk_exp(e));
    end
  endtask

  task automatic test_jump();
    obs_t o; exp_t e;
    do_instr(8'h01, 16'hE042, 1'b0, 0, 0, 1'b1, 8'h42, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e) || !o.single || !o.req_after) begin
      fails++; $display("FAIL jmp_issue: got=%h single=%b next_req=%b expected=%h single=1 next_req=1",
                        pk_obs(o), o.single, o.req_after, pk_exp(e));
    end
    do_instr(8'h42, 16'h3333, 1'b0, 0, 0, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e) || !o.req_ok) begin
      fails++; $display("FAIL jmp_target_fetch: got=%h addr_ok=%b expected=%h addr_ok=1", pk_obs(o), o.req_ok, pk_exp(e));
    end
  endtask

  task automatic test_jz();
    obs_t o; exp_t e;
    do_instr(8'h10, 16'hF010, 1'b1, 0, 0, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e)) begin
      fails++; $display("FAIL jz_taken: got=%h expected=%h", pk_obs(o), pk_exp(e));
    end
    do_instr(8'h11, 16'hF010, 1'b0, 0, 0, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e)) begin
      fails++; $display("FAIL jz_not_taken: got=%h expected=%h", pk_obs(o), pk_exp(e));
    end
  endtask

  task automatic test_stall();
    obs_t o; exp_t e;
    do_instr(8'h20, 16'h7ABC, 1'b0, 0, 3, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e)) begin
      fails++; $display("FAIL busy_issue: got=%h expected=%h", pk_obs(o), pk_exp(e));
    end
    checks++;
    if ({o.lat, o.quiet, o.single} !== {32'd7, 2'b11}) begin
      fails++; $display("FAIL busy_timing: lat=%0d quiet=%b single=%b expected lat=7 quiet=1 single=1",
                        o.lat, o.quiet, o.single);
    end
    do_instr(8'h21, 16'hE0C3, 1'b0, 2, 0, 1'b1, 8'h22, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e)) begin
      fails++; $display("FAIL ack_delay_issue: got=%h expected=%h", pk_obs(o), pk_exp(e));
    end
    checks++;
    if ({o.lat, o.req_ok, o.req_after} !== {32'd6, 2'b11}) begin
      fails++; $display("FAIL ack_delay_timing: lat=%0d addr_ok=%b next_req=%b expected lat=6 (period 7) addr_ok=1 next_req=1",
                        o.lat, o.req_ok, o.req_after);
    end
    do_instr(8'h22, 16'h1111, 1'b0, 0, 0, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e) || !o.req_ok) begin
      fails++; $display("FAIL ack_delay_next: got=%h addr_ok=%b expected=%h addr_ok=1", pk_obs(o), o.req_ok, pk_exp(e));
    end
  endtask

  task automatic test_ack_last();
    obs_t o; exp_t e;
    do_instr(8'h5A, 16'h5A5A, 1'b0, 14, 0, 1'b0, 8'h00, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e) || fetch_err !== 1'b0 || o.lat != 18) begin
      fails++; $display("FAIL ack_on_last_cycle: got=%h err=%b lat=%0d expected=%h err=0 lat=18",
                        pk_obs(o), fetch_err, o.lat, pk_exp(e));
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    n = 0;
    ins_addr = 8'h77; mem_ack = 1'b0; enable = 1'b1;
    while (!mem_req && n < 8) begin step(); n++; end
    ok = mem_req;
    for (int i = 0; i < 15; i++) begin
      step();
      ok &= (mem_req && !fetch_err && mem_addr == 8'h77);
    end
    checks++;
    if (!ok) begin
      fails++; $display("FAIL timeout_wait: wait_ok=%b expected 1 (req high, no err for 15 WAIT cycles)", ok);
    end
    step();
    checks++;
    if ({fetch_err, mem_req} !== 2'b10) begin
      fails++; $display("FAIL timeout_err: err=%b req=%b expected err=1 req=0", fetch_err, mem_req);
    end
    ok = 1'b1;
    repeat (5) begin
      step();
      ok &= (!mem_req && fetch_err && !instr_valid && !pc_inc && !pc_load);
    end
    checks++;
    if (!ok) begin
      fails++; $display("FAIL timeout_stop_held: stop_ok=%b expected 1", ok);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_vec !== 38'h0) begin
      fails++; $display("FAIL timeout_reset: outputs=%h expected=%h", out_vec, 38'h0);
    end
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_halt();
    obs_t o; exp_t e;
    bit ok;
    do_instr(8'h30, 16'h0000, 1'b0, 0, 0, 1'b1, 8'h31, o);
    e = sb.pop_front();
    checks++;
    if (pk_obs(o) !== pk_exp(e)) begin
      fails++; $display("FAIL halt_issue: got=%h expected=%h", pk_obs(o), pk_exp(e));
    end
    ok = !o.req_after;
    repeat (6) begin
      step();
      ok &= (!mem_req && halted && !instr_valid);
    end
    checks++;
    if (!ok) begin
      fails++; $display("FAIL halt_no_fetch: stop_ok=%b expected 1", ok);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    n = 0;
    ins_addr = 8'h44; mem_ack = 1'b0; enable = 1'b1;
    while (!mem_req && n < 8) begin step(); n++; end
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      fails++; $display("FAIL mid_wait_req: req=%b expected 1", mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr} !== 9'h0) begin
      fails++; $display("FAIL mid_wait_reset: req=%b addr=%h expected req=0 addr=00", mem_req, mem_addr);
    end
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump();
    test_jz();
    test_stall();
    test_ack_last();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
